// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of the DMemory_IO data port.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties).
module dmem_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          write0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          write1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t        state, state_nx;
    logic [3:0]    wait_cnt, wait_cnt_nx;
    logic          last_grant, last_grant_nx;
    logic          winner, winner_nx;
    logic [AW-1:0] mem_addr_nx;
    logic [DW-1:0] mem_wdata_nx;
    logic          mem_write_nx, mem_read_nx;
    logic          ack0_nx, ack1_nx;
    logic [DW-1:0] rdata0_nx, rdata1_nx;
    logic          grant1;
    logic          write_w;

    // last_grant == 1 means requester 1 was served last, so requester 0 wins the next tie
`ifdef ARB_FIXED_PRIO_EN
    assign grant1 = req1 & ~req0;
`else
    assign grant1 = req1 & (~req0 | ~last_grant);
`endif
    assign write_w = grant1 ? write1 : write0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            last_grant <= 1'b1;
            winner     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_cnt_nx;
            last_grant <= last_grant_nx;
            winner     <= winner_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            mem_write  <= mem_write_nx;
            mem_read   <= mem_read_nx;
            ack0       <= ack0_nx;
            ack1       <= ack1_nx;
            rdata0     <= rdata0_nx;
            rdata1     <= rdata1_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        wait_cnt_nx   = wait_cnt;
        last_grant_nx = last_grant;
        winner_nx     = winner;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        mem_write_nx  = mem_write;
        mem_read_nx   = mem_read;
        ack0_nx       = 1'b0;
        ack1_nx       = 1'b0;
        rdata0_nx     = rdata0;
        rdata1_nx     = rdata1;

        unique case (state)
            IDLE: begin
                mem_write_nx = 1'b0;
                mem_read_nx  = 1'b0;
                if (req0 | req1) begin
                    winner_nx     = grant1;
                    last_grant_nx = grant1;
                    mem_addr_nx   = grant1 ? addr1 : addr0;
                    mem_wdata_nx  = grant1 ? wdata1 : wdata0;
                    mem_write_nx  = write_w;
                    mem_read_nx   = ~write_w;
                    wait_cnt_nx   = WAIT_INIT;
                    state_nx      = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt == 4'd0) begin
                    // Final BUSY edge: the memory commits any write, read data is captured here
                    if (!mem_write) begin
                        if (winner) rdata1_nx = mem_rdata;
                        else        rdata0_nx = mem_rdata;
                    end
                    ack0_nx      = ~winner;
                    ack1_nx      = winner;
                    mem_write_nx = 1'b0;
                    mem_read_nx  = 1'b0;
                    state_nx     = ACK;
                end else begin
                    wait_cnt_nx = wait_cnt - 4'd1;
                end
            end
            ACK: begin
                mem_write_nx = 1'b0;
                mem_read_nx  = 1'b0;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one zero-wait instance and one with three wait states.
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // zero-wait instance
    logic          req0, write0, req1, write1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write, mem_read;

    // three-wait-state instance
    logic          w_req0, w_write0, w_req1, w_write1;
    logic [AW-1:0] w_addr0, w_addr1;
    logic [DW-1:0] w_wdata0, w_wdata1;
    logic          w_ack0, w_ack1;
    logic [DW-1:0] w_rdata0, w_rdata1;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata, w_mem_rdata;
    logic          w_mem_write, w_mem_read;

    logic [DW-1:0] mem   [0:255];
    logic [DW-1:0] w_mem [0:255];
    logic          load_en, load_sel;
    logic [7:0]    load_addr;
    logic [DW-1:0] load_data;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(0)) u_dut (
        .clock(clock), .reset(reset),
        .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(3)) u_dut_ws (
        .clock(clock), .reset(reset),
        .req0(w_req0), .write0(w_write0), .addr0(w_addr0), .wdata0(w_wdata0), .ack0(w_ack0), .rdata0(w_rdata0),
        .req1(w_req1), .write1(w_write1), .addr1(w_addr1), .wdata1(w_wdata1), .ack1(w_ack1), .rdata1(w_rdata1),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_write(w_mem_write), .mem_read(w_mem_read),
        .mem_rdata(w_mem_rdata)
    );

    // Memory models: combinational read, write on the rising edge while dwrite is high
    assign mem_rdata   = mem[mem_addr[7:0]];
    assign w_mem_rdata = w_mem[w_mem_addr[7:0]];

    always @(posedge clock) begin
        if (load_en && !load_sel) mem[load_addr] <= load_data;
        else if (mem_write)       mem[mem_addr[7:0]] <= mem_wdata;
    end

    always @(posedge clock) begin
        if (load_en && load_sel) w_mem[load_addr] <= load_data;
        else if (w_mem_write)    w_mem[w_mem_addr[7:0]] <= w_mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic sel, input logic [7:0] a, input logic [DW-1:0] d);
        load_sel  = sel;
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        tick();
        load_en   = 1'b0;
    endtask

    always @(negedge clock) begin
        check("excl_strobe",    32'(mem_write & mem_read), 32'd0);
        check("excl_ack",       32'(ack0 & ack1), 32'd0);
        check("excl_strobe_ws", 32'(w_mem_write & w_mem_read), 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_grant [4];
        int   cyc;
        int   acks;

`ifdef ARB_FIXED_PRIO_EN
        exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        reset = 1'b1;
        req0 = 0; write0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; write1 = 0; addr1 = '0; wdata1 = '0;
        w_req0 = 0; w_write0 = 0; w_addr0 = '0; w_wdata0 = '0;
        w_req1 = 0; w_write1 = 0; w_addr1 = '0; w_wdata1 = '0;
        load_en = 0; load_sel = 0; load_addr = '0; load_data = '0;

        load(1'b0, 8'd5, 16'h1234);
        load(1'b0, 8'd7, 16'h0000);
        load(1'b0, 8'd9, 16'h5A5A);
        load(1'b1, 8'd3, 16'hCAFE);
        reset = 1'b0;

        check("rst_ack0",   32'(ack0), 32'd0);
        check("rst_ack1",   32'(ack1), 32'd0);
        check("rst_rdata0", 32'(rdata0), 32'd0);
        check("rst_rdata1", 32'(rdata1), 32'd0);
        check("rst_addr",   32'(mem_addr), 32'd0);
        check("rst_wdata",  32'(mem_wdata), 32'd0);
        check("rst_strobe", 32'({mem_write, mem_read}), 32'd0);
        tick();

        // 1: requester 0 read
        req0 = 1; write0 = 0; addr0 = 16'd5;
        tick();
        check("t1_read_c1", 32'(mem_read), 32'd1);
        check("t1_addr_c1", 32'(mem_addr), 32'd5);
        check("t1_ack0_c1", 32'(ack0), 32'd0);
        check("t1_ack1_c1", 32'(ack1), 32'd0);
        tick();
        check("t1_ack0_c2",  32'(ack0), 32'd1);
        check("t1_rdata0",   32'(rdata0), 32'h1234);
        check("t1_read_c2",  32'(mem_read), 32'd0);
        check("t1_ack1_c2",  32'(ack1), 32'd0);
        req0 = 0;
        tick();
        check("t1_ack0_c3",  32'(ack0), 32'd0);
        check("t1_ack1_c3",  32'(ack1), 32'd0);
        check("t1_rdata0_h", 32'(rdata0), 32'h1234);

        // 2: requester 1 write then read back
        req1 = 1; write1 = 1; addr1 = 16'd7; wdata1 = 16'hBEEF;
        tick();
        check("t2_write_c1", 32'(mem_write), 32'd1);
        check("t2_read_c1",  32'(mem_read), 32'd0);
        check("t2_wdata",    32'(mem_wdata), 32'hBEEF);
        tick();
        check("t2_ack1_w",   32'(ack1), 32'd1);
        check("t2_rdata1_w", 32'(rdata1), 32'd0);
        check("t2_write_c2", 32'(mem_write), 32'd0);
        check("t2_mem7",     32'(mem[7]), 32'hBEEF);
        req1 = 0;
        tick();
        check("t2_ack1_off", 32'(ack1), 32'd0);
        req1 = 1; write1 = 0; addr1 = 16'd7;
        tick();
        check("t2_read_r",   32'(mem_read), 32'd1);
        tick();
        check("t2_ack1_r",   32'(ack1), 32'd1);
        check("t2_ack0_r",   32'(ack0), 32'd0);
        check("t2_rdata1_r", 32'(rdata1), 32'hBEEF);
        check("t2_rdata0_k", 32'(rdata0), 32'h1234);
        req1 = 0;
        tick();

        // 3: both requesters held for four accesses
        req0 = 1; write0 = 0; addr0 = 16'd5;
        req1 = 1; write1 = 0; addr1 = 16'd7;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!(ack0 | ack1) && cyc < 8);
            check("t3_ack_seen", 32'(ack0 | ack1), 32'd1);
            check("t3_spacing",  32'(cyc), (k == 0) ? 32'd2 : 32'd3);
            check("t3_grant",    32'(ack1), 32'(exp_grant[k]));
            check("t3_rdata",    ack1 ? 32'(rdata1) : 32'(rdata0), ack1 ? 32'hBEEF : 32'h1234);
        end
        req0 = 0; req1 = 0;
        tick();
        tick();

        // 5: reset in the middle of a write
        req0 = 1; write0 = 1; addr0 = 16'd9; wdata0 = 16'h00FF;
        tick();
        check("t5_write_busy", 32'(mem_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_write_rst",  32'(mem_write), 32'd0);
        check("t5_ack0_rst",   32'(ack0), 32'd0);
        check("t5_rdata0_rst", 32'(rdata0), 32'd0);
        check("t5_addr_rst",   32'(mem_addr), 32'd0);
        req0 = 0;
        tick();
        #2 reset = 1'b0;
        check("t5_mem9",       32'(mem[9]), 32'h5A5A);
        req0 = 1; write0 = 0; addr0 = 16'd9;
        tick();
        check("t5_read_c1",    32'(mem_read), 32'd1);
        tick();
        check("t5_ack0",       32'(ack0), 32'd1);
        check("t5_rdata0",     32'(rdata0), 32'h5A5A);
        req0 = 0;
        tick();

        // 4: three wait states
        w_req0 = 1; w_write0 = 0; w_addr0 = 16'd3;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("t4_read", 32'(w_mem_read), (i <= 4) ? 32'd1 : 32'd0);
            check("t4_ack",  32'(w_ack0), (i == 5) ? 32'd1 : 32'd0);
        end
        check("t4_rdata0", 32'(w_rdata0), 32'hCAFE);
        w_req0 = 0;
        tick();

        // 6: request dropped after the first BUSY cycle
        w_req0 = 1; w_addr0 = 16'd3;
        tick();
        w_req0 = 0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            acks += int'(w_ack0);
        end
        check("t6_ack_once", 32'(acks), 32'd1);
        check("t6_idle",     32'({w_mem_read, w_mem_write, w_ack0}), 32'd0);
        w_req0 = 1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!w_ack0 && cyc < 12);
        check("t6_relatency", 32'(cyc), 32'd5);
        w_req0 = 0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
